// File: rtl/axi_protocol_checker_if.sv
// AXI4 bus bundle shared by masters, slaves and the passive protocol checker.
// A transfer on any channel happens on a rising aclk edge where that channel's valid and ready are both high.
interface axi_protocol_checker_if #(
  parameter int AXI_DATA_W = 8,
  parameter int AXI_ADDR_W = 8,
  parameter int AXI_ID_W   = 8,
  parameter int AXI_USER_W = 1
);
  logic [AXI_ID_W-1:0]     awid;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic [AXI_USER_W-1:0]   awuser;
  logic                    awvalid;
  logic                    awready;

  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic [AXI_USER_W-1:0]   wuser;
  logic                    wvalid;
  logic                    wready;

  logic [AXI_ID_W-1:0]     bid;
  logic [1:0]              bresp;
  logic [AXI_USER_W-1:0]   buser;
  logic                    bvalid;
  logic                    bready;

  logic [AXI_ID_W-1:0]     arid;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic [AXI_USER_W-1:0]   aruser;
  logic                    arvalid;
  logic                    arready;

  logic [AXI_ID_W-1:0]     rid;
  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [AXI_USER_W-1:0]   ruser;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );

  modport monitor (
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid, awready,
    input wdata, wstrb, wlast, wuser, wvalid, wready,
    input bid, bresp, buser, bvalid, bready,
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid, arready,
    input rid, rdata, rresp, rlast, ruser, rvalid, rready
  );
endinterface

// File: rtl/axi_protocol_checker.sv
// Passive AXI4 checker: sticky stability/length/outstanding error flags plus write/read outstanding counters.
// Optional AXI_CHK_TIMEOUT_EN builds per-channel VALID-without-READY stall counters driving flag 9.
module axi_protocol_checker #(
  parameter int AXI_DATA_W      = 8,
  parameter int AXI_ADDR_W      = 8,
  parameter int AXI_ID_W        = 8,
  parameter int AXI_USER_W      = 1,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 256,
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  axi_protocol_checker_if.monitor bus,
  input  logic                  clear_err,
  output logic [9:0]            err_flags,
  output logic                  err_pulse,
  output logic [3:0]            err_first,
  output logic [CW-1:0]         wr_outstanding,
  output logic [CW-1:0]         rd_outstanding
);
  localparam int PW    = $clog2(MAX_OUTSTANDING);
  localparam int AX_PW = AXI_ID_W + AXI_ADDR_W + AXI_USER_W + 29;
  localparam int W_PW  = AXI_DATA_W + AXI_DATA_W / 8 + 1 + AXI_USER_W;
  localparam int B_PW  = AXI_ID_W + 2 + AXI_USER_W;
  localparam int R_PW  = AXI_ID_W + AXI_DATA_W + 3 + AXI_USER_W;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [4:0] vld, rdy, stall_now, stall_q, stable_err;
  logic [AX_PW-1:0] aw_pl_d, aw_pl_q, ar_pl_d, ar_pl_q;
  logic [W_PW-1:0]  w_pl_d, w_pl_q;
  logic [B_PW-1:0]  b_pl_d, b_pl_q;
  logic [R_PW-1:0]  r_pl_d, r_pl_q;

  assign aw_hs = bus.awvalid & bus.awready;
  assign w_hs  = bus.wvalid  & bus.wready;
  assign b_hs  = bus.bvalid  & bus.bready;
  assign ar_hs = bus.arvalid & bus.arready;
  assign r_hs  = bus.rvalid  & bus.rready;
  assign vld = {bus.rvalid, bus.arvalid, bus.bvalid, bus.wvalid, bus.awvalid};
  assign rdy = {bus.rready, bus.arready, bus.bready, bus.wready, bus.awready};
  assign stall_now = vld & ~rdy;

  assign aw_pl_d = {bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awlock,
                    bus.awcache, bus.awprot, bus.awqos, bus.awregion, bus.awuser};
  assign w_pl_d  = {bus.wdata, bus.wstrb, bus.wlast, bus.wuser};
  assign b_pl_d  = {bus.bid, bus.bresp, bus.buser};
  assign ar_pl_d = {bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arlock,
                    bus.arcache, bus.arprot, bus.arqos, bus.arregion, bus.aruser};
  assign r_pl_d  = {bus.rid, bus.rdata, bus.rresp, bus.rlast, bus.ruser};

  // A stalled channel must keep valid high and its payload frozen until the handshake.
  assign stable_err[0] = stall_q[0] & (~vld[0] | (aw_pl_d != aw_pl_q));
  assign stable_err[1] = stall_q[1] & (~vld[1] | (w_pl_d  != w_pl_q));
  assign stable_err[2] = stall_q[2] & (~vld[2] | (b_pl_d  != b_pl_q));
  assign stable_err[3] = stall_q[3] & (~vld[3] | (ar_pl_d != ar_pl_q));
  assign stable_err[4] = stall_q[4] & (~vld[4] | (r_pl_d  != r_pl_q));

  logic [7:0]    aw_mem_q [MAX_OUTSTANDING];
  logic [7:0]    aw_mem_d [MAX_OUTSTANDING];
  logic [8:0]    wb_mem_q [MAX_OUTSTANDING];
  logic [8:0]    wb_mem_d [MAX_OUTSTANDING];
  logic [PW-1:0] aw_wptr_q, aw_wptr_d, aw_rptr_q, aw_rptr_d;
  logic [PW-1:0] wb_wptr_q, wb_wptr_d, wb_rptr_q, wb_rptr_d;
  logic [CW-1:0] aw_cnt_q, aw_cnt_d, wb_cnt_q, wb_cnt_d;
  logic [CW-1:0] paired_q, paired_d, wr_out_q, wr_out_d, rd_out_q, rd_out_d;
  logic [8:0]    wbeat_q, wbeat_d;
  logic          wb_push_req, beat_overrun, pair, len_mismatch;
  logic          aw_ovf, aw_push, wb_ovf, wb_push, ar_ovf, b_unexp, r_unexp, timeout_hit;
  logic [9:0]    new_flags, err_flags_q, err_flags_d;
  logic          err_pulse_q, err_pulse_d;
  logic [3:0]    err_first_q, err_first_d, first_idx;

  always_comb begin
    wbeat_d      = wbeat_q;
    wb_push_req  = 1'b0;
    beat_overrun = 1'b0;
    if (w_hs) begin
      if (bus.wlast) begin
        wb_push_req = 1'b1;
        wbeat_d     = '0;
      end else if (wbeat_q == 9'd256) begin
        beat_overrun = 1'b1;
        wbeat_d      = '0;
      end else begin
        wbeat_d = wbeat_q + 9'd1;
      end
    end

    // Both heads present: retire one AW against one W burst this cycle.
    pair         = (aw_cnt_q != '0) && (wb_cnt_q != '0);
    len_mismatch = pair && (({1'b0, aw_mem_q[aw_rptr_q]} + 9'd1) != wb_mem_q[wb_rptr_q]);
    aw_ovf  = aw_hs && (aw_cnt_q == CW'(MAX_OUTSTANDING)) && !pair;
    aw_push = aw_hs && !aw_ovf;
    wb_ovf  = wb_push_req && (wb_cnt_q == CW'(MAX_OUTSTANDING)) && !pair;
    wb_push = wb_push_req && !wb_ovf;

    aw_mem_d  = aw_mem_q;
    wb_mem_d  = wb_mem_q;
    aw_wptr_d = aw_wptr_q;
    wb_wptr_d = wb_wptr_q;
    aw_rptr_d = aw_rptr_q;
    wb_rptr_d = wb_rptr_q;
    if (aw_push) begin
      aw_mem_d[aw_wptr_q] = bus.awlen;
      aw_wptr_d           = aw_wptr_q + PW'(1);
    end
    if (wb_push) begin
      wb_mem_d[wb_wptr_q] = wbeat_q + 9'd1;
      wb_wptr_d           = wb_wptr_q + PW'(1);
    end
    if (pair) begin
      aw_rptr_d = aw_rptr_q + PW'(1);
      wb_rptr_d = wb_rptr_q + PW'(1);
    end
    aw_cnt_d = aw_cnt_q + CW'(aw_push) - CW'(pair);
    wb_cnt_d = wb_cnt_q + CW'(wb_push) - CW'(pair);

    // Decrements at zero are dropped; the unexpected-response flag reports them instead.
    b_unexp  = b_hs && (paired_q == '0);
    paired_d = paired_q + CW'(pair && (paired_q != '1)) - CW'(b_hs && !b_unexp);
    wr_out_d = wr_out_q + CW'(aw_push && (wr_out_q != '1)) - CW'(b_hs && (wr_out_q != '0));
    ar_ovf   = ar_hs && (rd_out_q == CW'(MAX_OUTSTANDING));
    r_unexp  = r_hs && (rd_out_q == '0);
    rd_out_d = rd_out_q + CW'(ar_hs && !ar_ovf) - CW'(r_hs && bus.rlast && (rd_out_q != '0));

    new_flags = {timeout_hit, aw_ovf | wb_ovf | ar_ovf, r_unexp, b_unexp,
                 len_mismatch | beat_overrun, stable_err};

    first_idx = '0;
    for (int i = 9; i >= 0; i--) begin
      if (new_flags[i]) first_idx = 4'(i);
    end
    // A clear and a fresh error in the same cycle leave the fresh error set.
    err_flags_d = (clear_err ? 10'd0 : err_flags_q) | new_flags;
    err_pulse_d = |(new_flags & ~err_flags_q);
    err_first_d = clear_err ? 4'd0 : err_first_q;
    if ((clear_err || (err_flags_q == '0)) && (new_flags != '0)) err_first_d = first_idx;
  end

`ifdef AXI_CHK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] stall_cnt_q [5];
  logic [TW-1:0] stall_cnt_d [5];

  always_comb begin
    timeout_hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stall_cnt_d[i] = '0;
      if (stall_now[i]) begin
        if (stall_cnt_q[i] == TW'(TIMEOUT_CYCLES)) stall_cnt_d[i] = stall_cnt_q[i];
        else stall_cnt_d[i] = stall_cnt_q[i] + TW'(1);
        if (stall_cnt_q[i] == TW'(TIMEOUT_CYCLES - 1)) timeout_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) stall_cnt_q <= '{default: '0};
    else        stall_cnt_q <= stall_cnt_d;
  end
`else
  // TIMEOUT_CYCLES only matters for the stall-counter build.
  localparam logic TIMEOUT_OK = (TIMEOUT_CYCLES >= 2);
  assign timeout_hit = 1'b0 & TIMEOUT_OK;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stall_q     <= '0;
      aw_pl_q     <= '0;
      w_pl_q      <= '0;
      b_pl_q      <= '0;
      ar_pl_q     <= '0;
      r_pl_q      <= '0;
      aw_mem_q    <= '{default: '0};
      wb_mem_q    <= '{default: '0};
      aw_wptr_q   <= '0;
      aw_rptr_q   <= '0;
      wb_wptr_q   <= '0;
      wb_rptr_q   <= '0;
      aw_cnt_q    <= '0;
      wb_cnt_q    <= '0;
      paired_q    <= '0;
      wr_out_q    <= '0;
      rd_out_q    <= '0;
      wbeat_q     <= '0;
      err_flags_q <= '0;
      err_pulse_q <= 1'b0;
      err_first_q <= '0;
    end else begin
      stall_q     <= stall_now;
      aw_pl_q     <= aw_pl_d;
      w_pl_q      <= w_pl_d;
      b_pl_q      <= b_pl_d;
      ar_pl_q     <= ar_pl_d;
      r_pl_q      <= r_pl_d;
      aw_mem_q    <= aw_mem_d;
      wb_mem_q    <= wb_mem_d;
      aw_wptr_q   <= aw_wptr_d;
      aw_rptr_q   <= aw_rptr_d;
      wb_wptr_q   <= wb_wptr_d;
      wb_rptr_q   <= wb_rptr_d;
      aw_cnt_q    <= aw_cnt_d;
      wb_cnt_q    <= wb_cnt_d;
      paired_q    <= paired_d;
      wr_out_q    <= wr_out_d;
      rd_out_q    <= rd_out_d;
      wbeat_q     <= wbeat_d;
      err_flags_q <= err_flags_d;
      err_pulse_q <= err_pulse_d;
      err_first_q <= err_first_d;
    end
  end

  assign err_flags      = err_flags_q;
  assign err_pulse      = err_pulse_q;
  assign err_first      = err_first_q;
  assign wr_outstanding = wr_out_q;
  assign rd_outstanding = rd_out_q;
endmodule

// File: tb/tb_axi_protocol_checker.sv
// Directed bench for axi_protocol_checker: expected error events are queued by the stimulus and
// popped by a monitor on every err_pulse; counters and flags are also checked at fixed points.
module tb_axi_protocol_checker;
  localparam int MAXO = 8;
  localparam int TO   = 16;
  localparam int CW   = $clog2(MAXO) + 1;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          clear_err = 1'b0;
  logic [9:0]    err_flags;
  logic          err_pulse;
  logic [3:0]    err_first;
  logic [CW-1:0] wr_outstanding, rd_outstanding;

  int checks = 0;
  int failures = 0;
  logic [13:0] exp_q[$];  // {err_flags, err_first} expected at each err_pulse

  axi_protocol_checker_if #(.AXI_DATA_W(8), .AXI_ADDR_W(8), .AXI_ID_W(8), .AXI_USER_W(1)) bus ();

  axi_protocol_checker #(
    .AXI_DATA_W(8), .AXI_ADDR_W(8), .AXI_ID_W(8), .AXI_USER_W(1),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .areset(areset), .bus(bus), .clear_err(clear_err),
    .err_flags(err_flags), .err_pulse(err_pulse), .err_first(err_first),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [13:0] e;
    forever begin
      @(negedge aclk);
      if (!areset && err_pulse) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_err_pulse actual=flags %0h first %0d required=no pulse", err_flags, err_first);
        end else begin
          e = exp_q.pop_front();
          check("pulse_err_flags", 32'(err_flags), 32'(e[13:4]));
          check("pulse_err_first", 32'(err_first), 32'(e[3:0]));
        end
      end
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle_bus();
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awlock = '0;
    bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awregion = '0; bus.awuser = '0;
    bus.awvalid = 1'b0; bus.awready = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wuser = '0; bus.wvalid = 1'b0; bus.wready = 1'b0;
    bus.bid = '0; bus.bresp = '0; bus.buser = '0; bus.bvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arlock = '0;
    bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arregion = '0; bus.aruser = '0;
    bus.arvalid = 1'b0; bus.arready = 1'b0;
    bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0; bus.ruser = '0;
    bus.rvalid = 1'b0; bus.rready = 1'b0;
  endtask

  task automatic do_reset(input string name);
    areset = 1'b1;
    clear_err = 1'b0;
    idle_bus();
    settle(2);
    areset = 1'b0;
    step();
    check(name, 32'({err_flags, err_pulse, err_first, wr_outstanding, rd_outstanding}), 32'd0);
  endtask

  task automatic aw_txn(input logic [7:0] len);
    bus.awvalid = 1'b1; bus.awready = 1'b1; bus.awlen = len; bus.awaddr = 8'h40;
    step();
    bus.awvalid = 1'b0; bus.awready = 1'b0;
  endtask

  task automatic w_burst(input int beats);
    for (int i = 0; i < beats; i++) begin
      bus.wvalid = 1'b1; bus.wready = 1'b1; bus.wdata = 8'(i + 1); bus.wstrb = 1'b1;
      bus.wlast = (i == beats - 1);
      step();
    end
    bus.wvalid = 1'b0; bus.wready = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic drain_check(input string name);
    settle(2);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    idle_bus();
    fork
      monitor();
    join_none

    // Clean write: AWLEN=3, four beats, then B.
    do_reset("reset_t1");
    aw_txn(8'd3);
    check("t1_wr_out_after_aw", 32'(wr_outstanding), 32'd1);
    w_burst(4);
    settle(2);
    bus.bvalid = 1'b1; bus.bready = 1'b1;
    step();
    bus.bvalid = 1'b0; bus.bready = 1'b0;
    check("t1_wr_out_after_b", 32'(wr_outstanding), 32'd0);
    settle(1);
    check("t1_err_flags", 32'(err_flags), 32'd0);
    drain_check("t1_queue_drained");

    // AR payload changes while stalled.
    do_reset("reset_t2");
    exp_q.push_back({10'h008, 4'd3});
    bus.arvalid = 1'b1; bus.arready = 1'b0; bus.araddr = 8'h10;
    step();
    bus.araddr = 8'h14;
    step();
    check("t2_err_flags", 32'(err_flags), 32'h008);
    check("t2_err_first", 32'(err_first), 32'd3);
    bus.arready = 1'b1;
    step();
    bus.arvalid = 1'b0; bus.arready = 1'b0;
    check("t2_rd_out", 32'(rd_outstanding), 32'd1);
    drain_check("t2_queue_drained");

    // W before AW; second burst length disagrees with its AWLEN.
    do_reset("reset_t3");
    exp_q.push_back({10'h020, 4'd5});
    w_burst(4);
    w_burst(2);
    aw_txn(8'd3);
    settle(1);
    check("t3_pair1_ok", 32'(err_flags), 32'd0);
    aw_txn(8'd2);
    settle(2);
    check("t3_err_flags", 32'(err_flags), 32'h020);
    check("t3_wr_out", 32'(wr_outstanding), 32'd2);
    drain_check("t3_queue_drained");

    // Unexpected B, then clear coinciding with an unexpected R, then plain clear.
    do_reset("reset_t4");
    exp_q.push_back({10'h040, 4'd6});
    bus.bvalid = 1'b1; bus.bready = 1'b1;
    step();
    bus.bvalid = 1'b0; bus.bready = 1'b0;
    check("t4_wr_out_stays_0", 32'(wr_outstanding), 32'd0);
    check("t4_err_flags", 32'(err_flags), 32'h040);
    check("t4_err_first", 32'(err_first), 32'd6);
    settle(1);
    exp_q.push_back({10'h080, 4'd7});
    clear_err = 1'b1;
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1;
    step();
    clear_err = 1'b0;
    bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
    check("t4_clear_new_wins_flags", 32'(err_flags), 32'h080);
    check("t4_clear_new_wins_first", 32'(err_first), 32'd7);
    check("t4_rd_out_stays_0", 32'(rd_outstanding), 32'd0);
    settle(1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("t4_cleared", 32'({err_flags, err_first}), 32'd0);
    drain_check("t4_queue_drained");

    // Read overflow at MAX_OUTSTANDING, then drain, then one extra R.
    do_reset("reset_t5");
    exp_q.push_back({10'h100, 4'd8});
    bus.arvalid = 1'b1; bus.arready = 1'b1; bus.araddr = 8'h20;
    settle(8);
    check("t5_rd_out_full", 32'(rd_outstanding), 32'd8);
    check("t5_no_err_at_full", 32'(err_flags), 32'd0);
    step();
    bus.arvalid = 1'b0; bus.arready = 1'b0;
    check("t5_rd_out_saturated", 32'(rd_outstanding), 32'd8);
    check("t5_overflow_flag", 32'(err_flags), 32'h100);
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1;
    settle(8);
    check("t5_rd_out_drained", 32'(rd_outstanding), 32'd0);
    check("t5_flags_after_drain", 32'(err_flags), 32'h100);
    exp_q.push_back({10'h180, 4'd8});
    step();
    bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
    check("t5_rd_out_no_underflow", 32'(rd_outstanding), 32'd0);
    check("t5_r_unexpected", 32'({err_flags, err_first}), 32'({10'h180, 4'd8}));
    drain_check("t5_queue_drained");

    // W stalled with wready low.
    do_reset("reset_t6");
    bus.wvalid = 1'b1; bus.wready = 1'b0; bus.wlast = 1'b1; bus.wdata = 8'h5a;
    settle(TO - 1);
    check("t6_no_timeout_yet", 32'(err_flags), 32'd0);
`ifdef AXI_CHK_TIMEOUT_EN
    exp_q.push_back({10'h200, 4'd9});
    step();
    check("t6_timeout_flag", 32'(err_flags), 32'h200);
`else
    settle(5);
    check("t6_timeout_absent", 32'(err_flags), 32'd0);
`endif
    bus.wready = 1'b1;
    step();
    bus.wvalid = 1'b0; bus.wready = 1'b0; bus.wlast = 1'b0;
    drain_check("t6_queue_drained");

    // 257th W beat without wlast.
    do_reset("reset_t7");
    exp_q.push_back({10'h020, 4'd5});
    bus.wvalid = 1'b1; bus.wready = 1'b1; bus.wlast = 1'b0;
    settle(256);
    check("t7_256_beats_ok", 32'(err_flags), 32'd0);
    step();
    bus.wvalid = 1'b0; bus.wready = 1'b0;
    check("t7_beat_overrun", 32'(err_flags), 32'h020);
    drain_check("t7_queue_drained");

    // AW FIFO overflow with no write data.
    do_reset("reset_t8");
    exp_q.push_back({10'h100, 4'd8});
    bus.awvalid = 1'b1; bus.awready = 1'b1; bus.awlen = 8'd0;
    settle(9);
    bus.awvalid = 1'b0; bus.awready = 1'b0;
    check("t8_wr_out_saturated", 32'(wr_outstanding), 32'd8);
    check("t8_aw_overflow", 32'({err_flags, err_first}), 32'({10'h100, 4'd8}));
    drain_check("t8_queue_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
